// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

   localparam int DEF_ADDR_W = 64;
   localparam int DEF_DATA_W = 64;
   localparam int BE_W       = DEF_DATA_W / 8;

endpackage

// File: rtl/arb_starve_sel.sv
// Winner select between fetch and data requests, with a saturating fetch-starvation counter
// that forces a fetch grant once fetch has lost STARVE_LIMIT times in a row.
module arb_starve_sel #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_valid,
   input  logic d_valid,
   input  logic grant_en,
   output logic grant_i,
   output logic grant_d
);

   localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

   logic [3:0] starveCnt;

   assign grant_i = i_valid & (~d_valid | (starveCnt == Limit));
   assign grant_d = d_valid & ~grant_i;

   always_ff @(posedge clk) begin
      if (!reset) begin
         starveCnt <= '0;
      end else if (grant_en) begin
         if (grant_i) begin
            starveCnt <= '0;
         end else if (grant_d && i_valid && starveCnt != Limit) begin
            starveCnt <= starveCnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store data, one
// transaction in flight at a time, data first with guaranteed fetch forward progress.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   output logic                i_rsp_valid,
   output logic [DATA_W-1:0]   i_rsp_data,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic                d_req_we,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_be,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rsp_data,
   output logic                m_req_valid,
   input  logic                m_req_ready,
   output logic [ADDR_W-1:0]   m_req_addr,
   output logic                m_req_we,
   output logic [DATA_W-1:0]   m_req_wdata,
   output logic [DATA_W/8-1:0] m_req_be,
   input  logic                m_rsp_valid,
   input  logic [DATA_W-1:0]   m_rsp_data,
   output logic                err_spurious
);

   state_t state;
   owner_t owner;
   logic   grantEn;
   logic   grantI;
   logic   grantD;

   // Grants are only offered while idle and out of reset.
   assign grantEn     = reset & (state == S_IDLE);
   assign i_req_ready = grantEn & grantI;
   assign d_req_ready = grantEn & grantD;

   arb_starve_sel #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) uStarveSel (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_req_valid),
      .d_valid (d_req_valid),
      .grant_en(grantEn),
      .grant_i (grantI),
      .grant_d (grantD)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         owner        <= OWN_NONE;
         m_req_valid  <= 1'b0;
         m_req_addr   <= '0;
         m_req_we     <= 1'b0;
         m_req_wdata  <= '0;
         m_req_be     <= '0;
         i_rsp_valid  <= 1'b0;
         i_rsp_data   <= '0;
         d_rsp_valid  <= 1'b0;
         d_rsp_data   <= '0;
         err_spurious <= 1'b0;
      end else begin
         i_rsp_valid <= 1'b0;
         d_rsp_valid <= 1'b0;
         if (m_rsp_valid && state != S_RSP) begin
            err_spurious <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (grantI || grantD) begin
                  m_req_valid <= 1'b1;
                  m_req_addr  <= grantI ? i_req_addr : d_req_addr;
                  m_req_we    <= grantD & d_req_we;
                  m_req_wdata <= grantD ? d_req_wdata : '0;
                  // Reads of either port always fetch the full word.
                  m_req_be    <= (grantD && d_req_we) ? d_req_be : '1;
                  owner       <= grantI ? OWN_I : OWN_D;
                  state       <= S_REQ;
               end
            end
            S_REQ: begin
               if (m_req_ready) begin
                  m_req_valid <= 1'b0;
                  state       <= S_RSP;
               end
            end
            S_RSP: begin
               if (m_rsp_valid) begin
                  if (owner == OWN_I) begin
                     i_rsp_valid <= 1'b1;
                     i_rsp_data  <= m_rsp_data;
                  end else begin
                     d_rsp_valid <= 1'b1;
                     d_rsp_data  <= m_req_we ? '0 : m_rsp_data;
                  end
                  owner <= OWN_NONE;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus hand-written
// sequences for priority, starvation, memory stall, spurious response and mid-flight reset.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req_valid;
   logic        i_req_ready;
   logic [63:0] i_req_addr;
   logic        i_rsp_valid;
   logic [63:0] i_rsp_data;
   logic        d_req_valid;
   logic        d_req_ready;
   logic [63:0] d_req_addr;
   logic        d_req_we;
   logic [63:0] d_req_wdata;
   logic [7:0]  d_req_be;
   logic        d_rsp_valid;
   logic [63:0] d_rsp_data;
   logic        m_req_valid;
   logic        m_req_ready;
   logic [63:0] m_req_addr;
   logic        m_req_we;
   logic [63:0] m_req_wdata;
   logic [7:0]  m_req_be;
   logic        m_rsp_valid;
   logic [63:0] m_rsp_data;
   logic        err_spurious;

   mem_port_arbiter #(
      .ADDR_W      (64),
      .DATA_W      (64),
      .STARVE_LIMIT(4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_req_valid (i_req_valid),
      .i_req_ready (i_req_ready),
      .i_req_addr  (i_req_addr),
      .i_rsp_valid (i_rsp_valid),
      .i_rsp_data  (i_rsp_data),
      .d_req_valid (d_req_valid),
      .d_req_ready (d_req_ready),
      .d_req_addr  (d_req_addr),
      .d_req_we    (d_req_we),
      .d_req_wdata (d_req_wdata),
      .d_req_be    (d_req_be),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_data  (d_rsp_data),
      .m_req_valid (m_req_valid),
      .m_req_ready (m_req_ready),
      .m_req_addr  (m_req_addr),
      .m_req_we    (m_req_we),
      .m_req_wdata (m_req_wdata),
      .m_req_be    (m_req_be),
      .m_rsp_valid (m_rsp_valid),
      .m_rsp_data  (m_rsp_data),
      .err_spurious(err_spurious)
   );

   typedef struct {
      logic        iv;
      logic        dv;
      logic        we;
      logic [63:0] iaddr;
      logic [63:0] daddr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic [1:0]  expPort;   // 01 = fetch, 10 = data
      logic [63:0] expAddr;
      logic        expWe;
      logic [7:0]  expBe;
      logic [63:0] expWdata;
      logic [63:0] expRsp;
   } vec_t;

   int   nChecks = 0;
   int   nFail   = 0;
   int   stallLeft = 0;
   logic suppressRsp = 1'b0;
   logic injectSpur  = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] memData(input logic [63:0] a);
      return (a == 64'h8000_0000) ? 64'h13 : (a ^ 64'hDEAD_BEEF_0000_0000);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: optional stall at the start of each request, response one cycle after accept.
   initial begin
      logic        lastValid;
      logic [63:0] lastAddr;
      logic        hs;
      lastValid   = 1'b0;
      lastAddr    = '0;
      m_req_ready = 1'b0;
      m_rsp_valid = 1'b0;
      m_rsp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         hs          = lastValid && m_req_ready;
         m_rsp_valid = (hs && !suppressRsp) || injectSpur;
         m_rsp_data  = memData(lastAddr);
         injectSpur  = 1'b0;
         if (m_req_valid) begin
            if (stallLeft > 0) begin
               m_req_ready = 1'b0;
               stallLeft--;
            end else begin
               m_req_ready = 1'b1;
            end
         end else begin
            m_req_ready = 1'b0;
         end
         lastValid = m_req_valid;
         lastAddr  = m_req_addr;
      end
   end

   task automatic runTxn(input vec_t v, input string tag);
      int k;
      @(negedge clk);
      i_req_valid = v.iv;
      i_req_addr  = v.iaddr;
      d_req_valid = v.dv;
      d_req_addr  = v.daddr;
      d_req_we    = v.we;
      d_req_wdata = v.wdata;
      d_req_be    = v.be;
      #1;
      k = 0;
      while (!(i_req_ready || d_req_ready) && k < 10) begin
         @(negedge clk);
         #1;
         k++;
      end
      check({tag, "_grant"}, {62'b0, d_req_ready, i_req_ready}, {62'b0, v.expPort});
      @(posedge clk);
      @(negedge clk);
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      check({tag, "_mvalid"}, {63'b0, m_req_valid}, 64'd1);
      check({tag, "_maddr"}, m_req_addr, v.expAddr);
      check({tag, "_mwe"}, {63'b0, m_req_we}, {63'b0, v.expWe});
      check({tag, "_mbe"}, {56'b0, m_req_be}, {56'b0, v.expBe});
      check({tag, "_mwdata"}, m_req_wdata, v.expWdata);
      k = 1;
      while (!(i_rsp_valid || d_rsp_valid) && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_latency"}, 64'(k), 64'd3);
      check({tag, "_rspport"}, {62'b0, d_rsp_valid, i_rsp_valid}, {62'b0, v.expPort});
      check({tag, "_rspdata"}, v.expPort[0] ? i_rsp_data : d_rsp_data, v.expRsp);
   endtask

   function automatic vec_t mk(input logic iv, input logic dv, input logic we,
                               input logic [63:0] iaddr, input logic [63:0] daddr,
                               input logic [63:0] wdata, input logic [7:0] be,
                               input logic [1:0] ep, input logic [63:0] ea, input logic ewe,
                               input logic [7:0] ebe, input logic [63:0] ewd,
                               input logic [63:0] ersp);
      vec_t v;
      v.iv = iv; v.dv = dv; v.we = we; v.iaddr = iaddr; v.daddr = daddr; v.wdata = wdata;
      v.be = be; v.expPort = ep; v.expAddr = ea; v.expWe = ewe; v.expBe = ebe;
      v.expWdata = ewd; v.expRsp = ersp;
      return v;
   endfunction

   initial begin
      vec_t vecs[6];
      int   k;
      int   dRun;
      int   iGrants;
      logic [63:0] holdAddr;
      logic [7:0]  holdBe;
      logic        holdWe;

      vecs[0] = mk(1, 0, 0, 64'h8000_0000, 64'h0, 64'h0, 8'h00,
                   2'b01, 64'h8000_0000, 0, 8'hFF, 64'h0, 64'h13);
      vecs[1] = mk(0, 1, 0, 64'h0, 64'h1000, 64'h0, 8'h0F,
                   2'b10, 64'h1000, 0, 8'hFF, 64'h0, 64'hDEAD_BEEF_0000_1000);
      vecs[2] = mk(0, 1, 1, 64'h0, 64'h2000, 64'h1122_3344_5566_7788, 8'h0F,
                   2'b10, 64'h2000, 1, 8'h0F, 64'h1122_3344_5566_7788, 64'h0);
      vecs[3] = mk(0, 1, 1, 64'h0, 64'h3008, 64'hCAFE, 8'hFF,
                   2'b10, 64'h3008, 1, 8'hFF, 64'hCAFE, 64'h0);
      vecs[4] = mk(1, 0, 0, 64'h8000_0004, 64'h0, 64'h0, 8'h00,
                   2'b01, 64'h8000_0004, 0, 8'hFF, 64'h0, 64'hDEAD_BEEF_8000_0004);
      vecs[5] = mk(0, 1, 0, 64'h0, 64'h10, 64'h0, 8'h00,
                   2'b10, 64'h10, 0, 8'hFF, 64'h0, 64'hDEAD_BEEF_0000_0010);

      reset       = 1'b0;
      i_req_valid = 1'b0;
      i_req_addr  = '0;
      d_req_valid = 1'b0;
      d_req_addr  = '0;
      d_req_we    = 1'b0;
      d_req_wdata = '0;
      d_req_be    = '0;
      repeat (3) @(negedge clk);
      check("reset_mvalid", {63'b0, m_req_valid}, 64'd0);
      check("reset_maddr", m_req_addr, 64'd0);
      check("reset_rsp", {62'b0, i_rsp_valid, d_rsp_valid}, 64'd0);
      check("reset_err", {63'b0, err_spurious}, 64'd0);
      reset = 1'b1;

      for (int i = 0; i < 6; i++) runTxn(vecs[i], $sformatf("vec%0d", i));

      // Both ports valid: data store first, then the waiting fetch.
      @(negedge clk);
      i_req_valid = 1'b1; i_req_addr = 64'h8000_0008;
      d_req_valid = 1'b1; d_req_addr = 64'h5000; d_req_we = 1'b1;
      d_req_wdata = 64'hAB; d_req_be = 8'h0F;
      #1;
      check("both_grant", {62'b0, d_req_ready, i_req_ready}, 64'b10);
      @(posedge clk);
      @(negedge clk);
      d_req_valid = 1'b0;
      check("both_mwe", {63'b0, m_req_we}, 64'd1);
      check("both_mbe", {56'b0, m_req_be}, 64'h0F);
      k = 0;
      while (!d_rsp_valid && k < 20) begin @(negedge clk); k++; end
      check("both_drsp", {63'b0, d_rsp_valid}, 64'd1);
      check("both_fetch_next", {63'b0, i_req_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      i_req_valid = 1'b0;
      check("both_faddr", m_req_addr, 64'h8000_0008);
      k = 0;
      while (!i_rsp_valid && k < 20) begin @(negedge clk); k++; end
      check("both_fdata", i_rsp_data, 64'hDEAD_BEEF_8000_0008);

      // Starvation: both held valid; fetch must win after exactly four data grants, twice.
      @(negedge clk);
      i_req_valid = 1'b1; i_req_addr = 64'h8000_0000;
      d_req_valid = 1'b1; d_req_addr = 64'h100; d_req_we = 1'b0;
      dRun = 0; iGrants = 0; k = 0;
      #1;
      while (iGrants < 2 && k < 300) begin
         if (d_req_ready) dRun++;
         if (i_req_ready) begin
            check($sformatf("starve_run%0d", iGrants), 64'(dRun), 64'd4);
            dRun = 0;
            iGrants++;
         end
         if (iGrants < 2) begin
            @(negedge clk);
            #1;
            k++;
         end
      end
      check("starve_fetch_grants", 64'(iGrants), 64'd2);
      @(negedge clk);
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      repeat (6) @(negedge clk);

      // Memory stall: request fields frozen and no upstream grant while waiting.
      stallLeft   = 5;
      i_req_valid = 1'b1; i_req_addr = 64'h8000_0000;
      #1;
      check("stall_grant", {63'b0, i_req_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      i_req_valid = 1'b0;
      d_req_valid = 1'b1; d_req_addr = 64'h40; d_req_we = 1'b0;
      holdAddr = m_req_addr; holdBe = m_req_be; holdWe = m_req_we;
      k = 0;
      #1;
      while (m_req_valid && !m_req_ready && k < 20) begin
         k++;
         check("stall_addr", m_req_addr, holdAddr);
         check("stall_be_we", {55'b0, m_req_be, m_req_we}, {55'b0, holdBe, holdWe});
         check("stall_dready", {63'b0, d_req_ready}, 64'd0);
         @(negedge clk);
         #1;
      end
      d_req_valid = 1'b0;
      check("stall_cycles", 64'(k), 64'd5);
      check("stall_mvalid", {63'b0, m_req_valid}, 64'd1);
      k = 0;
      while (!i_rsp_valid && k < 20) begin @(negedge clk); k++; end
      check("stall_rsp", i_rsp_data, 64'h13);
      repeat (2) @(negedge clk);

      // Spurious response while idle.
      check("spur_before", {63'b0, err_spurious}, 64'd0);
      injectSpur = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("spur_norsp", {62'b0, i_rsp_valid, d_rsp_valid}, 64'd0);
      end
      check("spur_set", {63'b0, err_spurious}, 64'd1);
      repeat (4) @(negedge clk);
      check("spur_sticky", {63'b0, err_spurious}, 64'd1);

      // Reset while waiting for the memory response.
      suppressRsp = 1'b1;
      i_req_valid = 1'b1; i_req_addr = 64'h8000_0010;
      #1;
      check("rst_grant", {63'b0, i_req_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      i_req_valid = 1'b0;
      k = 0;
      while (!(m_req_valid && m_req_ready) && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      check("rst_in_rsp", {63'b0, m_req_valid}, 64'd0);
      reset = 1'b0;
      i_req_valid = 1'b1;
      #1;
      check("rst_ready_gated", {63'b0, i_req_ready}, 64'd0);
      @(negedge clk);
      check("rst_ready", {62'b0, i_req_ready, d_req_ready}, 64'd0);
      check("rst_valids", {61'b0, m_req_valid, i_rsp_valid, d_rsp_valid}, 64'd0);
      check("rst_maddr", m_req_addr, 64'd0);
      check("rst_mfields", {55'b0, m_req_be, m_req_we}, 64'd0);
      check("rst_mwdata", m_req_wdata, 64'd0);
      check("rst_idata", i_rsp_data, 64'd0);
      check("rst_ddata", d_rsp_data, 64'd0);
      check("rst_err", {63'b0, err_spurious}, 64'd0);
      i_req_valid = 1'b0;
      reset       = 1'b1;
      suppressRsp = 1'b0;
      injectSpur  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("late_norsp", {62'b0, i_rsp_valid, d_rsp_valid}, 64'd0);
      end
      check("late_err", {63'b0, err_spurious}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
